// File: rtl/boot_sequencer.sv
// Power-up sequencer: qualifies PLL lock, releases and waits on the SDRAM controller, configures
// the camera with bounded retries, then enables the LCD path. Lock loss restarts the sequence.
module boot_sequencer #(
  parameter int unsigned LOCK_STABLE_CYC = 1000,
  parameter int unsigned SDRAM_TMO_CYC   = 200000,
  parameter int unsigned CAM_TMO_CYC     = 2000000,
  parameter int unsigned CAM_RETRY_MAX   = 3,
  parameter int unsigned CNT_W           = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       sdram_init_done,
  input  logic       cam_cfg_done,
  input  logic       cam_cfg_err,
  output logic       sdram_rst_n,
  output logic       cam_cfg_start,
  output logic       lcd_en,
  output logic       sys_ready,
  output logic       fault,
  output logic [2:0] state
);

  localparam int unsigned RetryW = (CAM_RETRY_MAX > 0) ? $clog2(CAM_RETRY_MAX + 1) : 1;

  localparam logic [CNT_W-1:0]  LockLast  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0]  SdramLast = CNT_W'(SDRAM_TMO_CYC - 1);
  localparam logic [CNT_W-1:0]  CamLast   = CNT_W'(CAM_TMO_CYC - 1);
  localparam logic [RetryW-1:0] RetryMax  = RetryW'(CAM_RETRY_MAX);

  typedef enum logic [2:0] {
    StWaitLock  = 3'd0,
    StSdramInit = 3'd1,
    StCamStart  = 3'd2,
    StCamWait   = 3'd3,
    StRun       = 3'd4,
    StFault     = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d, timer_inc;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              lock_meta_q, locked_s_q;
  logic              sdram_rst_n_d, cam_cfg_start_d, lcd_en_d, sys_ready_d, fault_d;

  // Saturating increment; the timer never wraps back into a matching compare value.
  assign timer_inc = (timer_q == {CNT_W{1'b1}}) ? timer_q : timer_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta_q   <= 1'b0;
      locked_s_q    <= 1'b0;
      state_q       <= StWaitLock;
      timer_q       <= '0;
      retry_q       <= '0;
      sdram_rst_n   <= 1'b0;
      cam_cfg_start <= 1'b0;
      lcd_en        <= 1'b0;
      sys_ready     <= 1'b0;
      fault         <= 1'b0;
    end else begin
      lock_meta_q   <= pll_locked;
      locked_s_q    <= lock_meta_q;
      state_q       <= state_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      sdram_rst_n   <= sdram_rst_n_d;
      cam_cfg_start <= cam_cfg_start_d;
      lcd_en        <= lcd_en_d;
      sys_ready     <= sys_ready_d;
      fault         <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_inc;
    retry_d = retry_q;
    case (state_q)
      StWaitLock: begin
        if (!locked_s_q) begin
          timer_d = '0;
        end else if (timer_q == LockLast) begin
          state_d = StSdramInit;
          timer_d = '0;
        end
      end
      StSdramInit: begin
        if (sdram_init_done) begin
          state_d = StCamStart;
          timer_d = '0;
          retry_d = '0;
        end else if (timer_q == SdramLast) begin
          state_d = StFault;
        end
      end
      StCamStart: begin
        state_d = StCamWait;
        timer_d = '0;
      end
      StCamWait: begin
        // An error pulse wins over a simultaneous done pulse.
        if (cam_cfg_err || timer_q == CamLast) begin
          if (retry_q < RetryMax) begin
            retry_d = retry_q + 1'b1;
            state_d = StCamStart;
          end else begin
            state_d = StFault;
          end
        end else if (cam_cfg_done) begin
          state_d = StRun;
        end
      end
      StRun:   timer_d = '0;
      StFault: timer_d = '0;
      default: begin
        state_d = StWaitLock;
        timer_d = '0;
        retry_d = '0;
      end
    endcase
    // Lock loss overrides every other event; FAULT stays sticky.
    if (!locked_s_q && state_q inside {StSdramInit, StCamStart, StCamWait, StRun}) begin
      state_d = StWaitLock;
      timer_d = '0;
      retry_d = '0;
    end
  end

  // Outputs decode the next state so they are registered alongside it.
  always_comb begin
    sdram_rst_n_d   = 1'b0;
    cam_cfg_start_d = 1'b0;
    lcd_en_d        = 1'b0;
    sys_ready_d     = 1'b0;
    fault_d         = 1'b0;
    case (state_d)
      StSdramInit, StCamWait: sdram_rst_n_d = 1'b1;
      StCamStart: begin
        sdram_rst_n_d   = 1'b1;
        cam_cfg_start_d = 1'b1;
      end
      StRun: begin
        sdram_rst_n_d = 1'b1;
        lcd_en_d      = 1'b1;
        sys_ready_d   = 1'b1;
      end
      StFault: fault_d = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Bench for boot_sequencer: directed scenarios plus randomized camera responses, checked against
// a reference model of the attempt/timeout rules.
module tb_boot_sequencer;

  localparam int LOCK = 8;
  localparam int STMO = 50;
  localparam int CTMO = 40;
  localparam int RMAX = 2;

  typedef int arr5_t[5];

  logic       clk = 1'b0;
  logic       rst, pll_locked, sdram_init_done, cam_cfg_done, cam_cfg_err;
  logic       sdram_rst_n, cam_cfg_start, lcd_en, sys_ready, fault;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Results of run_camera and expectations from the model.
  int    r_pulses, r_end, r_wide, r_first;
  bit    r_hung;
  arr5_t r_gaps;
  int    e_pulses, e_end;
  arr5_t e_gaps;

  boot_sequencer #(
    .LOCK_STABLE_CYC(LOCK),
    .SDRAM_TMO_CYC  (STMO),
    .CAM_TMO_CYC    (CTMO),
    .CAM_RETRY_MAX  (RMAX),
    .CNT_W          (24)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .sdram_init_done(sdram_init_done),
    .cam_cfg_done   (cam_cfg_done),
    .cam_cfg_err    (cam_cfg_err),
    .sdram_rst_n    (sdram_rst_n),
    .cam_cfg_start  (cam_cfg_start),
    .lcd_en         (lcd_en),
    .sys_ready      (sys_ready),
    .fault          (fault),
    .state          (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Attempt i ends after dl+1 cycles on a response, or CTMO+1 on silence; done alone reaches RUN,
  // any error (including done+err) or timeout consumes a retry; retries exhausted -> FAULT.
  task automatic model(input arr5_t oc, input arr5_t dl);
    e_pulses = 0;
    e_end    = 5;
    for (int i = 0; i <= RMAX; i++) begin
      e_pulses  = i + 1;
      e_gaps[i] = (oc[i] == 2) ? CTMO + 1 : dl[i] + 1;
      if (oc[i] == 1) begin
        e_end = 4;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    sdram_init_done = 1'b0;
    cam_cfg_done = 1'b0;
    cam_cfg_err = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic lock_up(output int lat);
    pll_locked = 1'b1;
    lat = 0;
    while (!sdram_rst_n && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // oc per attempt: 0 err, 1 done, 2 silent, 3 done+err; dl = cycles from start to response.
  task automatic run_camera(input arr5_t oc, input arr5_t dl);
    int n, last, t0;
    r_pulses = 0; r_wide = 0; r_hung = 0; r_first = -1; last = 0; t0 = cyc;
    foreach (r_gaps[i]) r_gaps[i] = -1;
    for (int a = 0; a < 5; a++) begin
      n = 0;
      while (!(cam_cfg_start || state == 3'd4 || state == 3'd5) && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (n >= 300) begin
        r_hung = 1'b1;
        break;
      end
      if (a > 0) r_gaps[a-1] = cyc - last;
      else r_first = cyc - t0;
      if (!cam_cfg_start) break;
      r_pulses++;
      last = cyc;
      @(negedge clk);
      if (cam_cfg_start) r_wide++;
      if (oc[a] != 2) begin
        repeat (dl[a] - 1) @(negedge clk);
        cam_cfg_err  = (oc[a] == 0 || oc[a] == 3);
        cam_cfg_done = (oc[a] == 1 || oc[a] == 3);
        @(negedge clk);
        cam_cfg_err  = 1'b0;
        cam_cfg_done = 1'b0;
      end
    end
    r_end = int'(state);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pll_locked = 1'b0; sdram_init_done = 1'b0; cam_cfg_done = 1'b0; cam_cfg_err = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", state);
    end
    checks++;
    if ({sdram_rst_n, cam_cfg_start, lcd_en, sys_ready, fault} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {sdram_rst_n, cam_cfg_start, lcd_en, sys_ready, fault});
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (state !== 3'd0 || sdram_rst_n !== 1'b0) begin
      errors++; $display("FAIL unlocked_idle: got state %0d rst_n %b expected 0 0", state, sdram_rst_n);
    end
  endtask

  task automatic test_nominal();
    int lat;
    arr5_t oc = '{1, 2, 2, 2, 2};
    arr5_t dl = '{5, 1, 1, 1, 1};
    do_reset();
    lock_up(lat);
    checks++;
    if (lat != LOCK + 2) begin
      errors++; $display("FAIL nominal_lock_latency: got %0d expected %0d", lat, LOCK + 2);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (state !== 3'd1) begin
      errors++; $display("FAIL nominal_sdram_wait: got %0d expected 1", state);
    end
    sdram_init_done = 1'b1;
    run_camera(oc, dl);
    checks++;
    if (r_first != 1) begin
      errors++; $display("FAIL nominal_start_latency: got %0d expected 1", r_first);
    end
    checks++;
    if (r_pulses != 1 || r_wide != 0) begin
      errors++; $display("FAIL nominal_pulses: got %0d (wide %0d) expected 1 (wide 0)", r_pulses, r_wide);
    end
    checks++;
    if (r_gaps[0] != 6) begin
      errors++; $display("FAIL nominal_done_latency: got %0d expected 6", r_gaps[0]);
    end
    repeat (10) @(negedge clk);
    checks++;
    if ({state, sys_ready, lcd_en, sdram_rst_n, fault} !== {3'd4, 4'b1110}) begin
      errors++;
      $display("FAIL nominal_run: got %b expected %b",
               {state, sys_ready, lcd_en, sdram_rst_n, fault}, {3'd4, 4'b1110});
    end
  endtask

  task automatic test_lock_glitch();
    int lat;
    do_reset();
    pll_locked = 1'b1;
    repeat (5) @(negedge clk);
    pll_locked = 1'b0;
    @(negedge clk);
    lock_up(lat);
    checks++;
    if (lat != LOCK + 2) begin
      errors++; $display("FAIL glitch_latency: got %0d expected %0d", lat, LOCK + 2);
    end
  endtask

  task automatic check_scenario(input string name, input int init_delay, input arr5_t oc,
                                input arr5_t dl);
    int lat;
    do_reset();
    lock_up(lat);
    checks++;
    if (lat != LOCK + 2) begin
      errors++; $display("FAIL %s lock_latency: got %0d expected %0d", name, lat, LOCK + 2);
    end
    repeat (init_delay) @(negedge clk);
    sdram_init_done = 1'b1;
    model(oc, dl);
    run_camera(oc, dl);
    checks++;
    if (r_hung || r_pulses != e_pulses || r_wide != 0) begin
      errors++;
      $display("FAIL %s pulses: got %0d (wide %0d hung %0d) expected %0d",
               name, r_pulses, r_wide, r_hung, e_pulses);
    end
    for (int i = 0; i < e_pulses; i++) begin
      checks++;
      if (r_gaps[i] != e_gaps[i]) begin
        errors++; $display("FAIL %s gap%0d: got %0d expected %0d", name, i, r_gaps[i], e_gaps[i]);
      end
    end
    checks++;
    if (r_end != e_end) begin
      errors++; $display("FAIL %s end_state: got %0d expected %0d", name, r_end, e_end);
    end
    checks++;
    if ({sys_ready, lcd_en, fault, sdram_rst_n} !== ((e_end == 4) ? 4'b1101 : 4'b0010)) begin
      errors++;
      $display("FAIL %s end_outputs: got %b expected %b", name,
               {sys_ready, lcd_en, fault, sdram_rst_n}, (e_end == 4) ? 4'b1101 : 4'b0010);
    end
  endtask

  task automatic test_cam_retry();
    arr5_t dl;
    foreach (dl[i]) dl[i] = $urandom_range(1, 20);
    check_scenario("retry_ok",    3, '{0, 0, 1, 2, 2}, dl);
    check_scenario("retry_fault", 3, '{0, 0, 0, 2, 2}, dl);
    check_scenario("cam_timeout", 3, '{2, 2, 2, 2, 2}, dl);
    check_scenario("done_err",    3, '{3, 1, 2, 2, 2}, dl);
  endtask

  task automatic test_sdram_timeout();
    int lat, n;
    do_reset();
    lock_up(lat);
    n = 0;
    while (!fault && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != STMO) begin
      errors++; $display("FAIL sdram_timeout: got %0d expected %0d", n, STMO);
    end
    checks++;
    if (state !== 3'd5 || sdram_rst_n !== 1'b0) begin
      errors++; $display("FAIL sdram_fault_out: got state %0d rst_n %b expected 5 0", state, sdram_rst_n);
    end
    pll_locked = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (state !== 3'd5 || fault !== 1'b1) begin
      errors++; $display("FAIL fault_sticky_unlock: got state %0d fault %b expected 5 1", state, fault);
    end
    pll_locked = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (state !== 3'd5) begin
      errors++; $display("FAIL fault_sticky_relock: got %0d expected 5", state);
    end
  endtask

  task automatic test_lock_loss();
    int lat;
    arr5_t dl = '{4, 7, 2, 1, 1};
    arr5_t oc = '{0, 0, 1, 2, 2};
    do_reset();
    lock_up(lat);
    sdram_init_done = 1'b1;
    run_camera(oc, dl);
    checks++;
    if (r_end != 4) begin
      errors++; $display("FAIL loss_reach_run: got %0d expected 4", r_end);
    end
    pll_locked = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 3'd4) begin
      errors++; $display("FAIL loss_sync_delay: got %0d expected 4", state);
    end
    @(negedge clk);
    checks++;
    if ({state, lcd_en, sys_ready, sdram_rst_n, fault} !== 7'b0) begin
      errors++;
      $display("FAIL loss_restart: got %b expected 0000000",
               {state, lcd_en, sys_ready, sdram_rst_n, fault});
    end
    lock_up(lat);
    checks++;
    if (lat != LOCK + 2) begin
      errors++; $display("FAIL relock_latency: got %0d expected %0d", lat, LOCK + 2);
    end
    // Two more errors must still be tolerated, so the retry count was cleared.
    model(oc, dl);
    run_camera(oc, dl);
    checks++;
    if (r_end != e_end || r_pulses != e_pulses) begin
      errors++;
      $display("FAIL relock_retry: got end %0d pulses %0d expected end %0d pulses %0d",
               r_end, r_pulses, e_end, e_pulses);
    end
  endtask

  task automatic test_async_reset();
    int lat, n;
    do_reset();
    lock_up(lat);
    sdram_init_done = 1'b1;
    n = 0;
    while (!cam_cfg_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (state !== 3'd3) begin
      errors++; $display("FAIL async_precond: got %0d expected 3", state);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({state, sdram_rst_n, cam_cfg_start, lcd_en, sys_ready, fault} !== 8'b0) begin
      errors++;
      $display("FAIL async_reset: got %b expected 00000000",
               {state, sdram_rst_n, cam_cfg_start, lcd_en, sys_ready, fault});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    arr5_t oc, dl;
    for (int t = 0; t < 8; t++) begin
      foreach (oc[i]) begin
        oc[i] = $urandom_range(0, 3);
        dl[i] = $urandom_range(1, 20);
      end
      check_scenario($sformatf("rand%0d", t), $urandom_range(1, 40), oc, dl);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_nominal();
    test_lock_glitch();
    test_cam_retry();
    test_sdram_timeout();
    test_lock_loss();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
